// File: rtl/lab2_pkg.sv
// Shared types and constants for the lab2 self-test sweeper and its golden model.
package lab2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int              VEC_W    = 3;
    localparam logic [VEC_W-1:0] LAST_VEC = 3'b111;
    localparam int              ERR_W    = 4;
    localparam int              HOLD_W   = 4;

endpackage

// File: rtl/lab2_golden_xy.sv
// Reference behaviour of the combinational stage under test.
module lab2_golden_xy (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic x_exp,
    output logic y_exp
);

    assign x_exp = ~(c ^ (a | b));
    assign y_exp = a & b;

endmodule

// File: rtl/lab2_selftest.sv
// Exhaustive 3-input sweeper: drives every {a,b,c} vector into an external stage,
// compares its x/y returns against the golden model and keeps a mismatch summary.
module lab2_selftest
    import lab2_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_seen,
    output logic [VEC_W-1:0] first_fail
);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : gSettleCheck
            $error("lab2_selftest: SETTLE must be within 1..15");
        end
    endgenerate

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE - 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [ERR_W-1:0]   errCount_q, errCount_d;
    logic               failSeen_q, failSeen_d;
    logic [VEC_W-1:0]   firstFail_q, firstFail_d;

    logic xExp;
    logic yExp;
    logic mismatch;

    lab2_golden_xy uGolden (
        .a     (vec_q[2]),
        .b     (vec_q[1]),
        .c     (vec_q[0]),
        .x_exp (xExp),
        .y_exp (yExp)
    );

    assign mismatch = (x != xExp) || (y != yExp);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        hold_d      = hold_q;
        errCount_d  = errCount_q;
        failSeen_d  = failSeen_q;
        firstFail_d = firstFail_q;

        case (state_q)
            IDLE, DONE: begin
                // abort outranks start; otherwise a start launches a fresh sweep
                if (start && !abort) begin
                    state_d     = RUN;
                    vec_d       = '0;
                    hold_d      = '0;
                    errCount_d  = '0;
                    failSeen_d  = 1'b0;
                    firstFail_d = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d     = IDLE;
                    vec_d       = '0;
                    hold_d      = '0;
                    errCount_d  = '0;
                    failSeen_d  = 1'b0;
                    firstFail_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    if (mismatch) begin
                        errCount_d = errCount_q + 4'd1;
                        if (!failSeen_q) begin
                            failSeen_d  = 1'b1;
                            firstFail_d = vec_q;
                        end
                    end
                    hold_d = '0;
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + 3'd1;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            hold_q      <= '0;
            errCount_q  <= '0;
            failSeen_q  <= 1'b0;
            firstFail_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            hold_q      <= hold_d;
            errCount_q  <= errCount_d;
            failSeen_q  <= failSeen_d;
            firstFail_q <= firstFail_d;
        end
    end

    assign a          = vec_q[2];
    assign b          = vec_q[1];
    assign c          = vec_q[0];
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign pass       = (state_q == DONE) && (errCount_q == '0);
    assign err_count  = errCount_q;
    assign fail_seen  = failSeen_q;
    assign first_fail = firstFail_q;

endmodule

// File: tb/tb_lab2_selftest.sv
// Directed bench for lab2_selftest: three instances (SETTLE 2, 1, 15) share clock, reset,
// start and abort; each drives its own model of the stage under test with selectable faults.
module tb_lab2_selftest;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    int   mode = 0;

    int checks = 0;
    int errors = 0;

    logic x2, y2, a2, b2, c2, busy2, done2, pass2, fs2;
    logic [3:0] err2;
    logic [2:0] ff2;
    logic x1, y1, a1, b1, c1, busy1, done1, pass1, fs1;
    logic [3:0] err1;
    logic [2:0] ff1;
    logic x15, y15, a15, b15, c15, busy15, done15, pass15, fs15;
    logic [3:0] err15;
    logic [2:0] ff15;

    always #5 clk = ~clk;

    // Stage under test: mode 0 healthy, 1 x stuck at 0, 2 y inverted
    assign x2  = (mode == 1) ? 1'b0 : ~(c2 ^ (a2 | b2));
    assign y2  = (mode == 2) ? ~(a2 & b2) : (a2 & b2);
    assign x1  = (mode == 1) ? 1'b0 : ~(c1 ^ (a1 | b1));
    assign y1  = (mode == 2) ? ~(a1 & b1) : (a1 & b1);
    assign x15 = (mode == 1) ? 1'b0 : ~(c15 ^ (a15 | b15));
    assign y15 = (mode == 2) ? ~(a15 & b15) : (a15 & b15);

    lab2_selftest #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x(x2), .y(y2),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_seen(fs2), .first_fail(ff2)
    );

    lab2_selftest #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x(x1), .y(y1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_seen(fs1), .first_fail(ff1)
    );

    lab2_selftest #(.SETTLE(15)) dut15 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x(x15), .y(y15),
        .a(a15), .b(b15), .c(c15), .busy(busy15), .done(done15), .pass(pass15),
        .err_count(err15), .fail_seen(fs15), .first_fail(ff15)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic resetAll;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Pulses start for one edge, then waits (bounded) for done; cycles counts edges from the accept edge
    task automatic doSweep(output int cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        while (!done2 && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        tick();
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if ({a2, b2, c2, busy2, done2, pass2} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 000000", {a2, b2, c2, busy2, done2, pass2});
        end
        checks++;
        if ({err2, fs2, ff2} !== 8'b0) begin
            errors++;
            $display("[TB] FAIL reset_result got %b want 00000000", {err2, fs2, ff2});
        end
        tick();
        checks++;
        if (busy2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_stays busy got %b want 0", busy2);
        end
    endtask

    task automatic test_clean_sweep;
        int cycles;
        logic [2:0] expVec;
        mode = 0;
        resetAll();
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        while (busy2 && cycles < 200) begin
            expVec = 3'((cycles - 1) / 2);
            checks++;
            if ({a2, b2, c2} !== expVec) begin
                errors++;
                $display("[TB] FAIL sweep_vec cycle %0d got %b want %b", cycles, {a2, b2, c2}, expVec);
            end
            tick();
            cycles++;
        end
        checks++;
        if (cycles !== 17 || done2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clean_latency got %0d done=%b want 17 done=1", cycles, done2);
        end
        checks++;
        if ({pass2, err2, fs2, ff2, a2, b2, c2} !== {1'b1, 4'd0, 1'b0, 3'd0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL clean_result pass=%b err=%0d fs=%b ff=%b abc=%b want 1 0 0 000 000",
                     pass2, err2, fs2, ff2, {a2, b2, c2});
        end
    endtask

    task automatic test_x_stuck;
        int cycles;
        mode = 1;
        resetAll();
        doSweep(cycles);
        checks++;
        if ({done2, pass2, err2, fs2, ff2} !== {1'b1, 1'b0, 4'd4, 1'b1, 3'b000}) begin
            errors++;
            $display("[TB] FAIL x_stuck done=%b pass=%b err=%0d fs=%b ff=%b want 1 0 4 1 000",
                     done2, pass2, err2, fs2, ff2);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({done2, err2, fs2} !== {1'b1, 4'd4, 1'b1}) begin
            errors++;
            $display("[TB] FAIL abort_in_done done=%b err=%0d fs=%b want 1 4 1", done2, err2, fs2);
        end
        // restart straight out of DONE with a healthy stage
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy2, done2, err2, fs2, ff2} !== {1'b1, 1'b0, 4'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL restart_clear busy=%b done=%b err=%0d fs=%b ff=%b want 1 0 0 0 000",
                     busy2, done2, err2, fs2, ff2);
        end
        cycles = 1;
        while (!done2 && cycles < 200) begin
            tick();
            cycles++;
        end
        checks++;
        if ({cycles == 17, pass2, err2} !== {1'b1, 1'b1, 4'd0}) begin
            errors++;
            $display("[TB] FAIL restart_sweep cycles=%0d pass=%b err=%0d want 17 1 0", cycles, pass2, err2);
        end
    endtask

    task automatic test_y_inverted;
        int cycles;
        mode = 2;
        resetAll();
        doSweep(cycles);
        checks++;
        if ({done2, pass2, err2, fs2, ff2} !== {1'b1, 1'b0, 4'd8, 1'b1, 3'b000}) begin
            errors++;
            $display("[TB] FAIL y_inv done=%b pass=%b err=%0d fs=%b ff=%b want 1 0 8 1 000",
                     done2, pass2, err2, fs2, ff2);
        end
        mode = 0;
    endtask

    task automatic test_abort;
        int cycles;
        bit sawDone;
        mode = 1;
        resetAll();
        start = 1'b1;
        tick();
        start = 1'b0;
        // after accept edge (1) plus three 2-cycle windows, vector 011 is on the outputs
        repeat (6) tick();
        checks++;
        if ({a2, b2, c2, busy2, err2, fs2} !== {3'b011, 1'b1, 4'd1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL pre_abort abc=%b busy=%b err=%0d fs=%b want 011 1 1 1",
                     {a2, b2, c2}, busy2, err2, fs2);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({a2, b2, c2, busy2, done2, pass2, err2, fs2, ff2} !== 14'b0) begin
            errors++;
            $display("[TB] FAIL abort_clear got %b want all zero",
                     {a2, b2, c2, busy2, done2, pass2, err2, fs2, ff2});
        end
        sawDone = 1'b0;
        repeat (20) begin
            tick();
            if (done2) sawDone = 1'b1;
        end
        checks++;
        if (sawDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_done saw done=%b want 0", sawDone);
        end
        mode = 0;
        doSweep(cycles);
        checks++;
        if ({cycles == 17, pass2, err2, fs2} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL after_abort cycles=%0d pass=%b err=%0d fs=%b want 17 1 0 0",
                     cycles, pass2, err2, fs2);
        end
    endtask

    task automatic test_rst_and_start_rules;
        int cycles;
        mode = 0;
        resetAll();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        checks++;
        if ({a2, b2, c2, busy2} !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL pre_rst abc=%b busy=%b want 101 1", {a2, b2, c2}, busy2);
        end
        rst = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if ({a2, b2, c2, busy2, done2, pass2, err2, fs2, ff2} !== 14'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_run got %b want all zero",
                     {a2, b2, c2, busy2, done2, pass2, err2, fs2, ff2});
        end
        // start held high for the whole run must not restart the sweep
        start = 1'b1;
        tick();
        cycles = 1;
        while (!done2 && cycles < 200) begin
            tick();
            cycles++;
        end
        start = 1'b0;
        checks++;
        if ({cycles == 17, pass2} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL start_held cycles=%0d pass=%b want 17 1", cycles, pass2);
        end
        resetAll();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if ({busy2, done2} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL start_abort_idle busy=%b done=%b want 0 0", busy2, done2);
        end
    endtask

    task automatic test_settle_range;
        int n;
        int d1;
        int d15;
        mode = 0;
        resetAll();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        d1 = 0;
        d15 = 0;
        while (n < 300 && (d1 == 0 || d15 == 0)) begin
            if (done1 && d1 == 0) d1 = n;
            if (done15 && d15 == 0) d15 = n;
            if (d1 == 0 || d15 == 0) begin
                tick();
                n++;
            end
        end
        checks++;
        if (d1 !== 9) begin
            errors++;
            $display("[TB] FAIL settle1_latency got %0d want 9", d1);
        end
        checks++;
        if (d15 !== 121) begin
            errors++;
            $display("[TB] FAIL settle15_latency got %0d want 121", d15);
        end
        checks++;
        if ({pass1, pass15} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL settle_pass got %b want 11", {pass1, pass15});
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_x_stuck();
        test_y_inverted();
        test_abort();
        test_rst_and_start_rules();
        test_settle_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab2_selftest.md
LAB2_SELFTEST -- requirements
Module: lab2_selftest

Interface
REQ-001 Parameter SETTLE, default 2, meaning cycles each input vector is held before x/y are sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  level-sampled request to begin a sweep.
REQ-005 abort  input  1  level-sampled request to cancel a running sweep.
REQ-006 x  input  1  x output returned from the combinational stage under test.
REQ-007 y  input  1  y output returned from the combinational stage under test.
REQ-008 a, b, c  output  1 each  registered stimulus driven into the stage under test.
REQ-009 busy  output  1  high while a sweep runs.
REQ-010 done  output  1  high while results are valid and held.
REQ-011 pass  output  1  high only when done is high and err_count is 0.
REQ-012 err_count  output  4  number of mismatching vectors in the last sweep.
REQ-013 fail_seen  output  1  high when at least one mismatch has been captured.
REQ-014 first_fail  output  3  {a,b,c} of the first mismatching vector; 0 when fail_seen is 0.

Function
REQ-015 Golden model shall be: x_exp = XNOR(c, a OR b); y_exp = a AND b.
REQ-016 FSM shall have three states: IDLE, RUN and DONE.
REQ-017 IDLE with start=1 and abort=0 shall enter RUN next cycle, with {a,b,c}=000, hold counter=0, err_count=0, fail_seen=0 and first_fail=0.
REQ-018 RUN shall hold each vector for exactly SETTLE cycles, sampling x/y in the last cycle of the hold window.
REQ-019 On mismatch, err_count shall increment; if fail_seen is 0, the sampled vector shall load into first_fail and fail_seen shall set.
REQ-020 After a sample, a vector below 111 shall increment to vector+1 in the next cycle and the hold counter shall reset.
REQ-021 After vector 111 is sampled, the block shall enter DONE next cycle.
REQ-022 Latency from the start-accept edge to done=1 shall be 8*SETTLE+1 cycles (17 for default SETTLE).
REQ-023 busy shall equal (state==RUN); done shall equal (state==DONE).
REQ-024 DONE shall hold err_count, fail_seen, first_fail and pass stable; {a,b,c} shall return to 000.
REQ-025 DONE with start=1 shall restart per REQ-017 (direct DONE->RUN transition).
REQ-026 start while RUN shall be ignored.
REQ-027 abort while RUN shall enter IDLE next cycle, clear all outputs to 0 and leave done low.
REQ-028 abort in IDLE or DONE shall have no effect.
REQ-029 If abort and start are both high in the same cycle, abort shall win, and the block shall not start.
REQ-030 err_count shall never exceed 8; it needs no saturation logic.

Reset
REQ-031 rst=1 shall force IDLE, with a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_seen=0 and first_fail=0 on the next edge.
REQ-032 rst shall take priority over start and abort in every state, including mid-RUN.
REQ-033 No output shall be combinationally dependent on x or y; all outputs shall be registered or decoded from state.

Structure
REQ-034 A shared package lab2_pkg shall hold the state enum, the vector width (3), LAST_VEC=3'b111 and the err_count width (4).
REQ-035 The golden model shall be the combinational sub-module lab2_golden_xy (inputs a,b,c; outputs x_exp,y_exp), instantiated once.
REQ-036 The hold counter shall be 4 bits wide, and SETTLE shall be range-checked at elaboration.

Verification
REQ-037 Correct DUT, SETTLE=2, 1-cycle start pulse -> vectors 000..111 each held 2 cycles; done at cycle 17; pass=1; err_count=0; fail_seen=0.
REQ-038 x stuck-at-0 -> mismatch where x_exp=1 (vectors 000, 011, 101, 111); err_count=4; first_fail=000; pass=0.
REQ-039 y inverted -> err_count=8; first_fail=000; fail_seen=1.
REQ-040 abort asserted in vector 011 hold -> busy=0 and all outputs 0 next cycle; done never asserts; a following start gives a full clean sweep.
REQ-041 rst mid-RUN at vector 101 -> IDLE next edge with all outputs 0; start held high through RUN is ignored; start and abort together in IDLE -> no start.
REQ-042 Run with SETTLE=1 and SETTLE=15 -> done at cycles 9 and 121 respectively; restart from DONE clears the previous err_count.
